// File: rtl/addsub_result_fifo_if.sv
// Handshake bundle between the add/sub datapath, the result FIFO and its consumer.
// slave = FIFO view, master = producer/consumer view.
interface addsub_result_fifo_if #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_s;
    logic [SIZE-1:0] in_cout;
    logic            in_ctrl;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_s;
    logic [3:0]      out_flags;
    logic [CntW-1:0] count;

    modport slave (
        input  in_valid, in_s, in_cout, in_ctrl, out_ready,
        output in_ready, out_valid, out_s, out_flags, count
    );

    modport master (
        output in_valid, in_s, in_cout, in_ctrl, out_ready,
        input  in_ready, out_valid, out_s, out_flags, count
    );
endinterface

// File: rtl/addsub_result_fifo.sv
// Captures adder/subtractor results, derives NZCV flags and buffers them in a DEPTH-entry FIFO.
// Optional sticky overflow flag: define ADDSUB_FIFO_STICKY_OVF_EN.
module addsub_result_fifo #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
`ifdef ADDSUB_FIFO_STICKY_OVF_EN
    output logic sticky_ovf,
    input  logic sticky_clr,
`endif
    addsub_result_fifo_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [SIZE-1:0] s;
        logic [3:0]      flags;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full, empty, push, pop;
    logic [3:0]      flags_in;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    // Both handshakes use registered occupancy only: no full-pop or empty-push bypass.
    assign push  = bus.in_valid & ~full;
    assign pop   = bus.out_ready & ~empty;

    // {N, Z, C, V}; C is carry on add and borrow on subtract.
    assign flags_in = {bus.in_s[SIZE-1],
                       bus.in_s == '0,
                       bus.in_cout[SIZE-1] ^ bus.in_ctrl,
                       bus.in_cout[SIZE-1] ^ bus.in_cout[SIZE-2]};

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{s: bus.in_s, flags: flags_in};
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.in_ready  = ~full;
    assign bus.out_valid = ~empty;
    assign bus.out_s     = empty ? '0 : mem_q[rd_ptr_q].s;
    assign bus.out_flags = empty ? '0 : mem_q[rd_ptr_q].flags;
    assign bus.count     = count_q;

`ifdef ADDSUB_FIFO_STICKY_OVF_EN
    logic sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr) begin
            sticky_d = 1'b0;
        end
        if (push && flags_in[0]) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_ovf = sticky_q;
`endif
endmodule
